// File: rtl/dram_port_master_if.sv
// rtl/dram_port_master_if.sv - cache-side request/response and memory-side bus of the DRAM port master
interface dram_port_master_if #(
    parameter int ADDR_BITS  = 32,
    parameter int BLOCK_BITS = 256
);
    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_BITS-1:0]  req_addr;
    logic [BLOCK_BITS-1:0] req_wdata;
    logic                  req_ready;
    logic                  resp_valid;
    logic                  resp_write;
    logic [BLOCK_BITS-1:0] resp_rdata;
    logic                  resp_err;
    logic [ADDR_BITS-1:0]  addr;
    logic [BLOCK_BITS-1:0] din;
    logic                  en;
    logic                  we;
    logic [BLOCK_BITS-1:0] dout;
    logic                  dready;
    logic                  accR;
    logic                  accW;
    logic                  busy;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, dout, dready, accR, accW,
        output req_ready, resp_valid, resp_write, resp_rdata, resp_err, addr, din, en, we, busy
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, dout, dready, accR, accW,
        input  req_ready, resp_valid, resp_write, resp_rdata, resp_err, addr, din, en, we, busy
    );
endinterface

// File: rtl/dram_port_master.sv
// rtl/dram_port_master.sv - single-outstanding L2 block fill/writeback master towards a DRAM port
module dram_port_master #(
    parameter int ADDR_BITS  = 32,
    parameter int BLOCK_BITS = 256,
    parameter int TIMEOUT    = 63
) (
    input  logic               clk,
    input  logic               reset,
    dram_port_master_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]        TMO      = CW'(TIMEOUT);
    localparam logic [ADDR_BITS-1:0] OFF_MASK = ADDR_BITS'(BLOCK_BITS / 8 - 1);

    typedef enum logic [2:0] {IDLE, WAIT_ACC, ISSUE, WAIT_DATA, RESP} state_t;

    state_t                state, state_nx;
    logic                  write_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [BLOCK_BITS-1:0] wdata_q;
    logic [BLOCK_BITS-1:0] rdata_q;
    logic [CW-1:0]         cnt;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Both acceptance flags are required regardless of direction so a read never overtakes a posted write.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (bus.req_valid) state_nx = WAIT_ACC;
            WAIT_ACC:  if (bus.accR && bus.accW) state_nx = ISSUE;
            ISSUE:     state_nx = write_q ? RESP : WAIT_DATA;
            WAIT_DATA: begin
                if (bus.dready)      state_nx = RESP;
                else if (cnt == TMO) state_nx = IDLE;
            end
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.en         = 1'b0;
        bus.we         = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        case (state)
            IDLE:      bus.req_ready = !reset;
            ISSUE: begin
                bus.en = !write_q;
                bus.we = write_q;
            end
            WAIT_DATA: bus.resp_err = !bus.dready && (cnt == TMO);
            RESP:      bus.resp_valid = 1'b1;
            default:   ;
        endcase
        bus.busy = (state != IDLE);
    end

    // Counter reads 0 in ISSUE and k in the k-th cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr & ~OFF_MASK;
                wdata_q <= bus.req_wdata;
            end
            if (state == WAIT_DATA && bus.dready)
                rdata_q <= bus.dout;
            if (state == ISSUE || state == WAIT_DATA)
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;
        end
    end

    assign bus.addr       = addr_q;
    assign bus.din        = wdata_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_write = write_q;
endmodule
